mem_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_ctrl_if.sv | 56 +++++
 rtl/mem_ctrl_rr_arbiter.sv | 51 +++++
 rtl/mem_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared widths, FSM state encoding and client id type for the
//            two-client noun-cell RAM controller.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int c_ADDR_W = 10;
  localparam int c_DATA_W = 69;

  // Controller sequencing: accept, drive RAM, grab registered q, answer.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic [0:0] {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_if
// Brief    : Bundle of both client request/response channels plus the RAM
//            side (address, data, write enable, registered read data).
//            slave  = controller view, master = clients + RAM view.
// Revision : 1.0  initial release
// ============================================================================
interface mem_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) ();

  logic              req_valid_a;
  logic              req_ready_a;
  logic              req_write_a;
  logic [ADDR_W-1:0] req_addr_a;
  logic [DATA_W-1:0] req_wdata_a;
  logic              rsp_valid_a;
  logic [DATA_W-1:0] rsp_rdata_a;

  logic              req_valid_b;
  logic              req_ready_b;
  logic              req_write_b;
  logic [ADDR_W-1:0] req_addr_b;
  logic [DATA_W-1:0] req_wdata_b;
  logic              rsp_valid_b;
  logic [DATA_W-1:0] rsp_rdata_b;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req_valid_a, req_write_a, req_addr_a, req_wdata_a,
    input  req_valid_b, req_write_b, req_addr_b, req_wdata_b,
    input  mem_q,
    output req_ready_a, rsp_valid_a, rsp_rdata_a,
    output req_ready_b, rsp_valid_b, rsp_rdata_b,
    output mem_address, mem_data, mem_wren
  );

  modport master (
    output req_valid_a, req_write_a, req_addr_a, req_wdata_a,
    output req_valid_b, req_write_b, req_addr_b, req_wdata_b,
    output mem_q,
    input  req_ready_a, rsp_valid_a, rsp_rdata_a,
    input  req_ready_b, rsp_valid_b, rsp_rdata_b,
    input  mem_address, mem_data, mem_wren
  );

endinterface
`default_nettype wire

// File: rtl/mem_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Two-way grant. With MEM_CTRL_RR_EN defined a tie goes to the
//            client not granted last time (A counts as last after reset);
//            otherwise A always wins a tie and no history is kept.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
  import mem_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic i_valid_a,
  input  logic i_valid_b,
  input  logic i_accept,
  output logic o_grant_a,
  output logic o_grant_b
);

`ifdef MEM_CTRL_RR_EN
  owner_e r_last;

  // Record the winner of every accepted request so the next tie flips.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= CLIENT_A;
    end else if (i_accept) begin
      r_last <= o_grant_b ? CLIENT_B : CLIENT_A;
    end
  end

  // A lone requester wins; a tie goes to the client not served last.
  always_comb begin
    o_grant_a = i_valid_a && (!i_valid_b || (r_last == CLIENT_B));
    o_grant_b = i_valid_b && (!i_valid_a || (r_last == CLIENT_A));
  end
`else
  // History is not kept in fixed-priority builds.
  logic w_unused;
  assign w_unused = ^{clock, reset_n, i_accept};

  // Fixed priority: A wins every tie.
  always_comb begin
    o_grant_a = i_valid_a;
    o_grant_b = i_valid_b && !i_valid_a;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Two-client initiator for the 1024 x 69 single-port noun-cell
//            RAM. One access outstanding; hides the RAM's one-cycle read
//            latency and answers only the owning client.
//            Optional feature macro: MEM_CTRL_RR_EN (round-robin ties,
//            otherwise client A has fixed priority).
// Revision : 1.0  initial release
// ============================================================================
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic      clock,
  input  logic      reset_n,
  mem_ctrl_if.slave bus
);

  state_e            r_state;
  state_e            w_next_state;
  owner_e            r_owner;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_wren;
  logic              r_rsp_valid_a;
  logic              r_rsp_valid_b;
  logic [DATA_W-1:0] r_rsp_rdata_a;
  logic [DATA_W-1:0] r_rsp_rdata_b;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_ready_a;
  logic              w_ready_b;
  logic              w_accept;

  rr_arbiter u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_valid_a (bus.req_valid_a),
    .i_valid_b (bus.req_valid_b),
    .i_accept  (w_accept),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and request-ready: only the winner sees ready, only in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_ready_a    = 1'b0;
    w_ready_b    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_a = w_grant_a;
        w_ready_b = w_grant_b;
        if (w_grant_a || w_grant_b) begin
          w_next_state = ISSUE;
        end
      end
      // mem_wren still holds the request's write flag during ISSUE.
      ISSUE:   w_next_state = r_mem_wren ? RESP : CAPTURE;
      CAPTURE: w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept = w_ready_a || w_ready_b;

  // RAM drive: load on handshake, hold otherwise; write strobe lasts one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
      r_owner       <= CLIENT_A;
    end else if (w_accept) begin
      if (w_ready_b) begin
        r_mem_address <= bus.req_addr_b;
        r_mem_data    <= bus.req_wdata_b;
        r_mem_wren    <= bus.req_write_b;
        r_owner       <= CLIENT_B;
      end else begin
        r_mem_address <= bus.req_addr_a;
        r_mem_data    <= bus.req_wdata_a;
        r_mem_wren    <= bus.req_write_a;
        r_owner       <= CLIENT_A;
      end
    end else if (r_state == ISSUE) begin
      r_mem_wren <= 1'b0;
    end
  end

  // Responses: capture registered q for the owner, then pulse its valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid_a <= 1'b0;
      r_rsp_valid_b <= 1'b0;
      r_rsp_rdata_a <= '0;
      r_rsp_rdata_b <= '0;
    end else begin
      r_rsp_valid_a <= (r_state == RESP) && (r_owner == CLIENT_A);
      r_rsp_valid_b <= (r_state == RESP) && (r_owner == CLIENT_B);
      if (r_state == CAPTURE) begin
        if (r_owner == CLIENT_B) begin
          r_rsp_rdata_b <= bus.mem_q;
        end else begin
          r_rsp_rdata_a <= bus.mem_q;
        end
      end
    end
  end

  assign bus.req_ready_a = w_ready_a;
  assign bus.req_ready_b = w_ready_b;
  assign bus.rsp_valid_a = r_rsp_valid_a;
  assign bus.rsp_valid_b = r_rsp_valid_b;
  assign bus.rsp_rdata_a = r_rsp_rdata_a;
  assign bus.rsp_rdata_b = r_rsp_rdata_b;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data    = r_mem_data;
  assign bus.mem_wren    = r_mem_wren;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench for mem_ctrl with an external registered-read
//            RAM, a cycle-level behavioural reference model, directed
//            scenarios with literal expectations and a randomized phase.
//            Honours MEM_CTRL_RR_EN for the tie-break expectation.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;
  import mem_pkg::*;

  localparam int c_AW    = c_ADDR_W;
  localparam int c_DW    = c_DATA_W;
  localparam int c_DEPTH = 1 << c_AW;
`ifdef MEM_CTRL_RR_EN
  localparam bit c_RR = 1'b1;
`else
  localparam bit c_RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  mem_ctrl_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) bus ();

  mem_ctrl #(.ADDR_W(c_AW), .DATA_W(c_DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // External RAM: registered read, write on the same edge.
  logic [c_DW-1:0] ram [c_DEPTH];
  always @(posedge clock) begin
    if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
    bus.mem_q <= ram[bus.mem_address];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [c_DW-1:0] zx(input logic [c_AW-1:0] a);
    return {{(c_DW-c_AW){1'b0}}, a};
  endfunction

  function automatic logic [c_DW-1:0] rnd_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[c_DW-1:0];
  endfunction

  // ---------------- reference model (transaction timeline) ----------------
  // Cycle k = interval after the k-th posedge. A handshake sampled in cycle k:
  //   write -> strobe in k+1, RAM updated after k+1, response pulse in k+3
  //   read  -> response pulse with the pre-existing contents in k+4
  // and neither client may be accepted until the pulse cycle.
  logic [c_DW-1:0] model_mem [c_DEPTH];
  int              m_busy_until, m_wren_cyc, m_rsp_cyc, m_commit_cyc;
  bit              m_last_b, m_wr, m_rsp_b, m_rsp_rd, m_commit_pend;
  logic [c_AW-1:0] m_addr, m_c_addr;
  logic [c_DW-1:0] m_data, m_c_data, m_rsp_dat;
  int              wren_cnt = 0, rspa_cnt = 0, rspb_cnt = 0;

  always @(negedge clock) begin : p_check
    bit va, vb, ea, eb, wr;
    logic [c_AW-1:0] ad;
    logic [c_DW-1:0] wd;
    if (bus.mem_wren)    wren_cnt++;
    if (bus.rsp_valid_a) rspa_cnt++;
    if (bus.rsp_valid_b) rspb_cnt++;
    if (!reset_n) begin
      check_bit("rst_mem_wren", bus.mem_wren, 1'b0);
      check_bit("rst_rsp_valid_a", bus.rsp_valid_a, 1'b0);
      check_bit("rst_rsp_valid_b", bus.rsp_valid_b, 1'b0);
      check("rst_rsp_rdata_a", bus.rsp_rdata_a, '0);
      check("rst_rsp_rdata_b", bus.rsp_rdata_b, '0);
      check("rst_mem_address", zx(bus.mem_address), '0);
      check("rst_mem_data", bus.mem_data, '0);
      m_busy_until = -1; m_wren_cyc = -1; m_rsp_cyc = -1;
      m_last_b = 1'b0; m_commit_pend = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_data = '0;
    end else begin
      if (m_commit_pend && cyc == m_commit_cyc) begin
        model_mem[m_c_addr] = m_c_data;
        m_commit_pend = 1'b0;
      end
      va = bus.req_valid_a; vb = bus.req_valid_b;
      ea = 1'b0; eb = 1'b0;
      if (cyc > m_busy_until) begin
        if (va && vb) begin
          if (c_RR) begin eb = !m_last_b; ea = m_last_b; end
          else ea = 1'b1;
        end else begin
          ea = va; eb = vb;
        end
      end
      check_bit("req_ready_a", bus.req_ready_a, ea);
      check_bit("req_ready_b", bus.req_ready_b, eb);
      check_bit("mem_wren", bus.mem_wren, (cyc == m_wren_cyc) && m_wr);
      check("mem_address", zx(bus.mem_address), zx(m_addr));
      check("mem_data", bus.mem_data, m_data);
      check_bit("rsp_valid_a", bus.rsp_valid_a, (cyc == m_rsp_cyc) && !m_rsp_b);
      check_bit("rsp_valid_b", bus.rsp_valid_b, (cyc == m_rsp_cyc) && m_rsp_b);
      if (cyc == m_rsp_cyc && m_rsp_rd) begin
        if (m_rsp_b) check("rsp_rdata_b", bus.rsp_rdata_b, m_rsp_dat);
        else         check("rsp_rdata_a", bus.rsp_rdata_a, m_rsp_dat);
      end
      if (ea || eb) begin
        wr = eb ? bus.req_write_b : bus.req_write_a;
        ad = eb ? bus.req_addr_b  : bus.req_addr_a;
        wd = eb ? bus.req_wdata_b : bus.req_wdata_a;
        m_last_b = eb; m_addr = ad; m_data = wd; m_wr = wr;
        m_wren_cyc = cyc + 1; m_rsp_b = eb; m_rsp_rd = !wr;
        if (wr) begin
          m_busy_until = cyc + 2; m_rsp_cyc = cyc + 3;
          m_commit_pend = 1'b1; m_commit_cyc = cyc + 2;
          m_c_addr = ad; m_c_data = wd;
        end else begin
          m_busy_until = cyc + 3; m_rsp_cyc = cyc + 4;
          m_rsp_dat = model_mem[ad];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.req_valid_a = 1'b0; bus.req_write_a = 1'b0; bus.req_addr_a = '0; bus.req_wdata_a = '0;
    bus.req_valid_b = 1'b0; bus.req_write_b = 1'b0; bus.req_addr_b = '0; bus.req_wdata_b = '0;
  endtask

  task automatic drive(input bit cb, input bit v, input bit w, input logic [c_AW-1:0] ad, input logic [c_DW-1:0] d);
    if (cb) begin
      bus.req_valid_b = v; bus.req_write_b = w; bus.req_addr_b = ad; bus.req_wdata_b = d;
    end else begin
      bus.req_valid_a = v; bus.req_write_a = w; bus.req_addr_a = ad; bus.req_wdata_a = d;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clock); #2;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  // Present one request and wait (bounded) for its handshake cycle.
  task automatic send(input bit cb, input bit w, input logic [c_AW-1:0] ad, input logic [c_DW-1:0] d,
                      output int hs_cyc);
    bit ok;
    ok = 1'b0; hs_cyc = -1;
    @(posedge clock); #1;
    drive(cb, 1'b1, w, ad, d);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (cb ? bus.req_ready_b : bus.req_ready_a) begin ok = 1'b1; hs_cyc = cyc; break; end
    end
    @(posedge clock); #1;
    drive(cb, 1'b0, 1'b0, '0, '0);
    check_bit("send_handshake_seen", ok, 1'b1);
  endtask

  task automatic wait_rsp(input bit cb, output logic [c_DW-1:0] data, output int at_cyc);
    bit ok;
    ok = 1'b0; at_cyc = -1; data = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (cb ? bus.rsp_valid_b : bus.rsp_valid_a) begin
        ok = 1'b1; at_cyc = cyc;
        data = cb ? bus.rsp_rdata_b : bus.rsp_rdata_a;
        break;
      end
    end
    check_bit("rsp_seen", ok, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  localparam logic [c_DW-1:0] c_D1 = 69'h1_2345_6789_ABCD_EF01;
  localparam logic [c_DW-1:0] c_D6 = 69'h0_0000_0000_0BAD_CAFE;

  initial begin
    int hs, rc, w0, b0, a0, n, ra, ga, gb, seq;
    int hsl [8];
    logic [c_DW-1:0] d;
    logic [10:0] wide;
    bit ha, hb, got_a, got_b;

    for (int i = 0; i < c_DEPTH; i++) begin ram[i] = '0; model_mem[i] = '0; end
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;

    // Write then read 0x005 from A.
    w0 = wren_cnt; b0 = rspb_cnt;
    send(1'b0, 1'b1, 10'h005, c_D1, hs);
    wait_rsp(1'b0, d, rc);
    check_int("write_rsp_latency", rc - hs, 3);
    check_int("write_wren_cycles", wren_cnt - w0, 1);
    send(1'b0, 1'b0, 10'h005, '0, hs);
    wait_rsp(1'b0, d, rc);
    check_int("read_rsp_latency", rc - hs, 4);
    check("read_back_0x005", d, c_D1);
    check_int("rsp_b_never", rspb_cnt - b0, 0);

    // Tie from reset: A reads 0x010, B reads 0x020.
    do_reset();
    a0 = rspa_cnt; b0 = rspb_cnt;
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b0, 10'h010, '0);
    drive(1'b1, 1'b1, 1'b0, 10'h020, '0);
    got_a = 1'b0; got_b = 1'b0; ga = -1; gb = -1; seq = 0;
    for (int i = 0; i < 30 && !(got_a && got_b); i++) begin
      @(negedge clock);
      ha = bus.req_ready_a; hb = bus.req_ready_b;
      if (i == 0) begin
        check_bit("tie_first_ready_a", ha, !c_RR);
        check_bit("tie_first_ready_b", hb, c_RR);
      end
      if (ha) begin got_a = 1'b1; ga = seq++; end
      if (hb) begin got_b = 1'b1; gb = seq++; end
      @(posedge clock); #1;
      if (ha) drive(1'b0, 1'b0, 1'b0, '0, '0);
      if (hb) drive(1'b1, 1'b0, 1'b0, '0, '0);
    end
    check_bit("tie_both_granted", got_a && got_b, 1'b1);
    check_bit("tie_b_before_a", gb < ga, c_RR);
    repeat (8) @(negedge clock);
    check_int("tie_rsp_a_pulses", rspa_cnt - a0, 1);
    check_int("tie_rsp_b_pulses", rspb_cnt - b0, 1);

    // Cross-client read-after-write at the top address.
    send(1'b1, 1'b1, 10'h3FF, '1, hs);
    wait_rsp(1'b1, d, rc);
    send(1'b0, 1'b0, 10'h3FF, '0, hs);
    wait_rsp(1'b0, d, rc);
    check("raw_cross_client", d, '1);

    // A streams reads, B idle.
    n = 0; ra = 0;
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b0, 10'h3FF, '0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      if (bus.req_ready_a && n < 8) begin hsl[n] = cyc; n++; end
      if (bus.req_ready_b) ra++;
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check_bit("b2b_enough_handshakes", n >= 4, 1'b1);
    for (int i = 1; i < n; i++) check_int("b2b_spacing", hsl[i] - hsl[i-1], 4);
    check_int("b2b_ready_b_low", ra, 0);
    repeat (6) @(negedge clock);

    // Reset during ISSUE of a write to 0x001.
    a0 = rspa_cnt; w0 = wren_cnt;
    send(1'b0, 1'b1, 10'h001, 69'h0_0000_0000_0000_0ABC, hs);
    #1 reset_n = 1'b0;
    @(negedge clock);
    check_bit("rst_issue_wren_dropped", bus.mem_wren, 1'b0);
    @(posedge clock); #2 reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check_int("rst_issue_no_rsp", rspa_cnt - a0, 0);
    send(1'b0, 1'b0, 10'h001, '0, hs);
    wait_rsp(1'b0, d, rc);
    check("rst_issue_not_written", d, '0);

    // 11-bit address wraps onto 0x001.
    wide = 11'h401;
    send(1'b1, 1'b1, wide[9:0], c_D6, hs);
    wait_rsp(1'b1, d, rc);
    send(1'b0, 1'b0, 10'h001, '0, hs);
    wait_rsp(1'b0, d, rc);
    check("addr_wrap_0x401", d, c_D6);

    // Randomized traffic on a small address window, with two async resets.
    for (int i = 0; i < 900; i++) begin
      @(posedge clock); #1;
      drive(1'b0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), rnd_data());
      drive(1'b1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), rnd_data());
      if (i == 300 || i == 601) begin
        #1 reset_n = 1'b0;
        @(posedge clock); #2 reset_n = 1'b1;
      end
    end
    @(posedge clock); #1;
    idle_inputs();
    repeat (10) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d passed of %0d)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
